// File: rtl/seg_pkg.sv
// Shared constants for the single-digit seven-segment stage: state encoding
// and segment patterns (active-high, bit0 = a ... bit6 = g).
package seg_pkg;

    localparam logic [1:0] ST_LAMP = 2'd0;
    localparam logic [1:0] ST_STOP = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    localparam logic [6:0] SEG_ALL_ON = 7'h7F;
    localparam logic [6:0] SEG_OFF    = 7'h00;

    // Entry 15 first so that SEG_HEX[d] selects the pattern for digit d.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-digit to seven-segment decoder.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[digit];

endmodule

// File: rtl/seg_digit_counter.sv
// Single-digit up/down counter driving a registered seven-segment pattern,
// with a lamp test after reset and a prescaler setting the count rate.
//
// state | meaning
// ------+-----------------------------------------------------------
// LAMP  | all segments on for LAMP_CYCLES cycles; run/load ignored
// STOP  | digit frozen, prescaler held at 0; loads accepted
// RUN   | digit steps once every DIV cycles in direction dir_i
module seg_digit_counter
    import seg_pkg::*;
#(
    parameter int DIV         = 4,
    parameter int MAX_DIGIT   = 9,
    parameter int LAMP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       dir_i,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    output logic [3:0] digit_o,
    output logic [6:0] seg_o,
    output logic       tick_o,
    output logic       wrap_o,
    output logic       lamp_o
);

    localparam int PMAX = (DIV > LAMP_CYCLES) ? DIV : LAMP_CYCLES;
    localparam int PW   = $clog2(PMAX);

    localparam logic [PW-1:0] DIV_LAST  = PW'(DIV - 1);
    localparam logic [PW-1:0] LAMP_LAST = PW'(LAMP_CYCLES - 1);
    localparam logic [3:0]    MAX_D     = 4'(MAX_DIGIT);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [3:0]    digit_nxt;
    logic [3:0]    load_digit;
    logic          step;
    logic          wrap_nxt;
    logic [6:0]    seg_dec;

    assign load_digit = (load_val_i > MAX_D) ? 4'd0 : load_val_i;

    // Priority inside STOP/RUN: load, then stop request, then step.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        digit_nxt = digit_o;
        step      = 1'b0;
        wrap_nxt  = 1'b0;
        case (state)
            ST_LAMP: begin
                if (presc == LAMP_LAST) begin
                    state_nxt = ST_STOP;
                    presc_nxt = '0;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            ST_STOP: begin
                presc_nxt = '0;
                if (load_i) begin
                    digit_nxt = load_digit;
                end else if (run_i) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_i) begin
                    digit_nxt = load_digit;
                    presc_nxt = '0;
                end else if (!run_i) begin
                    state_nxt = ST_STOP;
                    presc_nxt = '0;
                end else if (presc == DIV_LAST) begin
                    presc_nxt = '0;
                    step      = 1'b1;
                    if (dir_i) begin
                        if (digit_o == MAX_D) begin
                            digit_nxt = 4'd0;
                            wrap_nxt  = 1'b1;
                        end else begin
                            digit_nxt = digit_o + 4'd1;
                        end
                    end else begin
                        if (digit_o == 4'd0) begin
                            digit_nxt = MAX_D;
                            wrap_nxt  = 1'b1;
                        end else begin
                            digit_nxt = digit_o - 4'd1;
                        end
                    end
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_LAMP;
                presc_nxt = '0;
            end
        endcase
    end

    // Decoding the next digit keeps seg_o and digit_o changing on the same edge.
    seg7_decode u_seg7_decode (
        .digit (digit_nxt),
        .seg   (seg_dec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_LAMP;
            presc   <= '0;
            digit_o <= 4'd0;
            seg_o   <= SEG_OFF;
            tick_o  <= 1'b0;
            wrap_o  <= 1'b0;
            lamp_o  <= 1'b0;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            digit_o <= digit_nxt;
            seg_o   <= (state == ST_LAMP) ? SEG_ALL_ON : seg_dec;
            tick_o  <= step;
            wrap_o  <= wrap_nxt;
            lamp_o  <= (state == ST_LAMP);
        end
    end

endmodule

// File: tb/tb_seg_digit_counter.sv
// Directed self-checking bench for seg_digit_counter with default parameters.
module tb_seg_digit_counter;

    logic       clk;
    logic       rst_n;
    logic       run_i;
    logic       dir_i;
    logic       load_i;
    logic [3:0] load_val_i;
    logic [3:0] digit_o;
    logic [6:0] seg_o;
    logic       tick_o;
    logic       wrap_o;
    logic       lamp_o;

    int n_checks;
    int n_fail;

    // Hand-written hex segment table, digit 0 first.
    logic [6:0] exp_seg [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg_digit_counter #(
        .DIV         (4),
        .MAX_DIGIT   (9),
        .LAMP_CYCLES (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run_i      (run_i),
        .dir_i      (dir_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .digit_o    (digit_o),
        .seg_o      (seg_o),
        .tick_o     (tick_o),
        .wrap_o     (wrap_o),
        .lamp_o     (lamp_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [3:0] d);
        chk({tag, " tick"}, 32'(tick_o), 32'd0);
        chk({tag, " digit"}, 32'(digit_o), 32'(d));
    endtask

    task automatic chk_step(input string tag, input logic [3:0] d, input logic w);
        chk({tag, " digit"}, 32'(digit_o), 32'(d));
        chk({tag, " seg"}, 32'(seg_o), 32'(exp_seg[d]));
        chk({tag, " tick"}, 32'(tick_o), 32'd1);
        chk({tag, " wrap"}, 32'(wrap_o), 32'(w));
    endtask

    task automatic chk_lamp(input string tag);
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk({tag, " lamp seg"}, 32'(seg_o), 32'h7F);
            chk({tag, " lamp_o"}, 32'(lamp_o), 32'd1);
        end
        cyc();
        chk({tag, " post seg"}, 32'(seg_o), 32'h3F);
        chk({tag, " post lamp"}, 32'(lamp_o), 32'd0);
        chk({tag, " post digit"}, 32'(digit_o), 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " digit"}, 32'(digit_o), 32'd0);
        chk({tag, " seg"}, 32'(seg_o), 32'h00);
        chk({tag, " tick"}, 32'(tick_o), 32'd0);
        chk({tag, " wrap"}, 32'(wrap_o), 32'd0);
        chk({tag, " lamp"}, 32'(lamp_o), 32'd0);
    endtask

    initial begin
        logic [3:0] d;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        run_i      = 1'b1;
        dir_i      = 1'b1;
        load_i     = 1'b0;
        load_val_i = 4'd0;

        cyc();
        cyc();
        chk_reset("reset");

        // run_i held high through the lamp test must not start counting early.
        rst_n = 1'b1;
        chk_lamp("lamp1");
        chk("stop->run tick", 32'(tick_o), 32'd0);

        // Count up through a full cycle; wrap only on 9 -> 0.
        d = 4'd0;
        for (int n = 1; n <= 10; n++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                chk_idle("up idle", d);
            end
            cyc();
            d = (d == 4'd9) ? 4'd0 : d + 4'd1;
            chk_step("up step", d, (n == 10));
        end

        // Load 2 and count down through the 0 -> 9 wrap.
        load_i = 1'b1; load_val_i = 4'd2; dir_i = 1'b0;
        cyc();
        load_i = 1'b0;
        chk("load2 digit", 32'(digit_o), 32'd2);
        chk("load2 seg", 32'(seg_o), 32'h5B);
        chk("load2 tick", 32'(tick_o), 32'd0);
        d = 4'd2;
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 3; k++) begin
                cyc();
                chk_idle("down idle", d);
            end
            cyc();
            d = (d == 4'd0) ? 4'd9 : d - 4'd1;
            chk_step("down step", d, (n == 2));
        end
        chk("down wrap seg", 32'(seg_o), 32'h6F);

        // Out-of-range load clamps to 0; an in-range load restarts the prescaler.
        load_i = 1'b1; load_val_i = 4'd12;
        cyc();
        chk("load12 digit", 32'(digit_o), 32'd0);
        chk("load12 seg", 32'(seg_o), 32'h3F);
        load_val_i = 4'd7; dir_i = 1'b1;
        cyc();
        load_i = 1'b0;
        chk("load7 digit", 32'(digit_o), 32'd7);
        chk("load7 seg", 32'(seg_o), 32'h07);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk_idle("load7 idle", 4'd7);
        end
        cyc();
        chk_step("load7 step", 4'd8, 1'b0);

        // Load coinciding with a step edge: load wins, no tick.
        for (int k = 0; k < 3; k++) cyc();
        load_i = 1'b1; load_val_i = 4'd3;
        cyc();
        load_i = 1'b0;
        chk("ld+step digit", 32'(digit_o), 32'd3);
        chk("ld+step seg", 32'(seg_o), 32'h4F);
        chk("ld+step tick", 32'(tick_o), 32'd0);
        chk("ld+step wrap", 32'(wrap_o), 32'd0);

        // run_i falling on a step edge: stop wins and the digit freezes.
        for (int k = 0; k < 3; k++) cyc();
        run_i = 1'b0;
        cyc();
        chk_idle("stop+step", 4'd3);
        for (int k = 0; k < 6; k++) cyc();
        chk_idle("stopped", 4'd3);

        // Load while stopped, start running, then reset mid-count.
        load_i = 1'b1; load_val_i = 4'd5;
        cyc();
        load_i = 1'b0;
        chk("stop load digit", 32'(digit_o), 32'd5);
        chk("stop load seg", 32'(seg_o), 32'h6D);
        run_i = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        chk_reset("midreset");
        rst_n = 1'b1; run_i = 1'b0;
        chk_lamp("lamp2");
        for (int k = 0; k < 6; k++) cyc();
        chk_idle("after lamp2", 4'd0);
        chk("after lamp2 seg", 32'(seg_o), 32'h3F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
